// File: rtl/seq_shift_unit_pkg.sv
// Shared types and constants for the sequential shift unit.
// Operation codes match the i_op encoding used by the execute stage.
package shift_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } shift_state_e;

    // Bits to shift this cycle: the full step, or whatever is left if smaller.
    function automatic logic [4:0] step_amount(input logic [4:0] rem, input logic [4:0] step);
        logic [4:0] amt;
        if (rem < step) begin
            amt = rem;
        end else begin
            amt = step;
        end
        return amt;
    endfunction

endpackage

// File: rtl/seq_shift_unit_step.sv
// Single iteration of the shifter: moves data by s positions for the given op.
// All shift arithmetic of the unit lives here.
module shift_step
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  shift_op_e       op,
    input  logic [4:0]      s,
    output logic [XLEN-1:0] data_next
);

    // SRA keeps data[31] at the original sign, so repeated steps fill correctly.
    always_comb begin
        data_next = data;
        case (op)
            OP_SLL:  data_next = data << s;
            OP_SRL:  data_next = data >> s;
            OP_SRA:  data_next = $signed(data) >>> s;
            default: data_next = data;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA responder: accepts one request in IDLE, shifts STEP
// bits per BUSY cycle and pulses o_valid with a registered result in DONE.
module seq_shift_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [4:0]      i_operand_b,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);
    import shift_pkg::*;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    shift_state_e    state_r;
    shift_state_e    state_nx_s;
    logic [XLEN-1:0] data_r;
    logic [XLEN-1:0] data_nx_s;
    logic [XLEN-1:0] step_data_s;
    logic [4:0]      rem_r;
    logic [4:0]      rem_nx_s;
    logic [4:0]      rem_dec_s;
    logic [4:0]      step_s;
    shift_op_e       op_r;
    shift_op_e       op_nx_s;
    logic [XLEN-1:0] result_r;
    logic [XLEN-1:0] result_nx_s;
    logic            valid_r;
    logic            valid_nx_s;

    assign step_s    = step_amount(rem_r, STEP_AMT);
    assign rem_dec_s = rem_r - step_s;

    shift_step u_step (
        .data      (data_r),
        .op        (op_r),
        .s         (step_s),
        .data_next (step_data_s)
    );

    // Next-state, datapath and output decode; flush wins over any request.
    always_comb begin
        state_nx_s  = state_r;
        data_nx_s   = data_r;
        rem_nx_s    = rem_r;
        op_nx_s     = op_r;
        result_nx_s = result_r;
        valid_nx_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_flush) begin
                    state_nx_s = S_IDLE;
                end else if (i_valid) begin
                    data_nx_s = i_operand_a;
                    rem_nx_s  = i_operand_b;
                    op_nx_s   = shift_op_e'(i_op);
                    if ((i_operand_b == 5'd0) || (i_op == 2'b11)) begin
                        state_nx_s  = S_DONE;
                        result_nx_s = i_operand_a;
                        valid_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = S_BUSY;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (i_flush) begin
                    state_nx_s = S_IDLE;
                end else begin
                    data_nx_s = step_data_s;
                    rem_nx_s  = rem_dec_s;
                    if (rem_dec_s == 5'd0) begin
                        state_nx_s  = S_DONE;
                        result_nx_s = step_data_s;
                        valid_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= S_IDLE;
            data_r   <= {XLEN{1'b0}};
            rem_r    <= 5'd0;
            op_r     <= OP_SLL;
            result_r <= {XLEN{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            data_r   <= data_nx_s;
            rem_r    <= rem_nx_s;
            op_r     <= op_nx_s;
            result_r <= result_nx_s;
            valid_r  <= valid_nx_s;
        end
    end

    assign o_ready  = (state_r == S_IDLE);
    assign o_valid  = valid_r;
    assign o_result = result_r;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: one instance with STEP=1, one with STEP=4.
// Expected results and completion cycles are queued at accept and checked on o_valid.
module tb_seq_shift_unit;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_in [2];
    logic [1:0]  op     [2];
    logic [31:0] opa    [2];
    logic [4:0]  opb    [2];
    logic        flush  [2];
    logic        ready  [2];
    logic        vld_out[2];
    logic [31:0] res    [2];

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] last_res[2];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_unit #(.XLEN(32), .STEP(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld_in[0]), .o_ready(ready[0]),
        .i_op(op[0]), .i_operand_a(opa[0]), .i_operand_b(opb[0]), .i_flush(flush[0]),
        .o_valid(vld_out[0]), .o_result(res[0])
    );

    seq_shift_unit #(.XLEN(32), .STEP(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld_in[1]), .o_ready(ready[1]),
        .i_op(op[1]), .i_operand_a(opa[1]), .i_operand_b(opb[1]), .i_flush(flush[1]),
        .o_valid(vld_out[1]), .o_result(res[1])
    );

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input logic [4:0] b);
        case (o)
            2'b00:   return a << b;
            2'b01:   return a >> b;
            2'b10:   return $signed(a) >>> b;
            default: return a;
        endcase
    endfunction

    task automatic push_exp(input int k, input logic [31:0] r, input int lat, input string nm);
        exp_t e;
        e.res  = r;
        e.cyc  = cyc + lat;
        e.name = nm;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        last_res[k] = r;
    endtask

    // Drive one request once the unit is ready; queue its expectation after the accept edge.
    task automatic issue(input int k, input logic [1:0] o, input logic [31:0] a, input logic [4:0] b,
                         input logic [31:0] exp_r, input string nm, input bit do_push, input bit keep);
        int n = 0;
        int st;
        int lat;
        st  = (k == 0) ? 1 : 4;
        lat = ((b == 5'd0) || (o == 2'b11)) ? 0 : (int'(b) + st - 1) / st;
        @(negedge clk);
        while (!ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(ready[k] == 1'b1, {nm, "_ready_wait"}, 32'(ready[k]), 32'd1);
        vld_in[k] = 1'b1;
        op[k]     = o;
        opa[k]    = a;
        opb[k]    = b;
        @(posedge clk);
        #1;
        if (do_push) push_exp(k, exp_r, lat, nm);
        if (!keep) vld_in[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(sb0.size() == 0 && sb1.size() == 0, "drain", 32'(sb0.size() + sb1.size()), 32'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (vld_out[0]) begin
                if (sb0.size() == 0) begin
                    check(1'b0, "unexpected_valid_step1", res[0], 32'd0);
                end else begin
                    e = sb0.pop_front();
                    check(res[0] == e.res, e.name, res[0], e.res);
                    check(cyc == e.cyc, {e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                end
            end
            if (vld_out[1]) begin
                if (sb1.size() == 0) begin
                    check(1'b0, "unexpected_valid_step4", res[1], 32'd0);
                end else begin
                    e = sb1.pop_front();
                    check(res[1] == e.res, e.name, res[1], e.res);
                    check(cyc == e.cyc, {e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    initial begin
        logic [31:0] avec [2];
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld_in[k] = 1'b0; op[k] = 2'b00; opa[k] = 32'h0; opb[k] = 5'd0; flush[k] = 1'b0;
            last_res[k] = 32'h0;
        end
        fork
            monitor();
        join_none
        #12;
        for (int k = 0; k < 2; k++) begin
            check(vld_out[k] == 1'b0, "reset_valid", 32'(vld_out[k]), 32'd0);
            check(ready[k] == 1'b1, "reset_ready", 32'(ready[k]), 32'd1);
            check(res[k] == 32'h0, "reset_result", res[k], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // STEP=1 directed shifts; ready must stay low while busy
        issue(0, 2'b00, 32'h0F0F0F0F, 5'd4, 32'hF0F0F0F0, "sll_b4", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(ready[0] == 1'b0, "busy_ready_low", 32'(ready[0]), 32'd0);
        end
        issue(0, 2'b10, 32'hF0F0F0F0, 5'd31, 32'hFFFFFFFF, "sra_b31", 1'b1, 1'b0);
        issue(0, 2'b01, 32'hF0F0F0F0, 5'd31, 32'h00000001, "srl_b31", 1'b1, 1'b0);
        drain();

        // STEP=4 sweep of every op and shift amount
        avec[0] = 32'h0F0F0F0F;
        avec[1] = 32'hF0F0F0F0;
        for (int ai = 0; ai < 2; ai++) begin
            for (int o = 0; o < 3; o++) begin
                for (int b = 0; b < 32; b++) begin
                    issue(1, 2'(o), avec[ai], 5'(b), ref_shift(2'(o), avec[ai], 5'(b)),
                          $sformatf("sweep_op%0d_a%h_b%0d", o, avec[ai], b), 1'b1, 1'b0);
                end
            end
        end
        drain();

        // Flush mid-BUSY: no pulse, ready back next cycle, result held
        issue(0, 2'b01, 32'hF0F0F0F0, 5'd20, 32'h0, "flushed", 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        @(negedge clk);
        check(ready[0] == 1'b1, "flush_ready", 32'(ready[0]), 32'd1);
        check(res[0] == last_res[0], "flush_result_held", res[0], last_res[0]);
        issue(0, 2'b00, 32'h00000001, 5'd3, 32'h00000008, "post_flush_sll", 1'b1, 1'b0);
        drain();

        // i_valid held through BUSY/DONE with changing operands, then reserved op
        issue(0, 2'b00, 32'h00000001, 5'd3, 32'h00000008, "hold_sll", 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!ready[0] && n < 50) begin
            op[0]  = 2'b10;
            opa[0] = $urandom;
            opb[0] = 5'($urandom_range(31, 1));
            @(negedge clk);
            n++;
        end
        check(ready[0] == 1'b1, "hold_ready_wait", 32'(ready[0]), 32'd1);
        op[0]  = 2'b11;
        opa[0] = 32'h12345678;
        opb[0] = 5'd9;
        @(posedge clk);
        #1;
        push_exp(0, 32'h12345678, 0, "rsvd_passthru");
        vld_in[0] = 1'b0;
        drain();

        // Asynchronous reset mid-BUSY
        issue(0, 2'b00, 32'h000000FF, 5'd20, 32'h0, "reset_victim", 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(vld_out[0] == 1'b0, "midreset_valid", 32'(vld_out[0]), 32'd0);
        check(ready[0] == 1'b1, "midreset_ready", 32'(ready[0]), 32'd1);
        check(res[0] == 32'h0, "midreset_result", res[0], 32'h0);
        last_res[0] = 32'h0;
        last_res[1] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check(res[0] == 32'h0, "post_reset_result", res[0], 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle shift responder for the execute stage of the non-forwarding RV32I core. It accepts one SLL/SRL/SRA request through a valid/ready handshake. It iterates the shift STEP bit positions per clock and returns the result with a one-cycle o_valid pulse. It exists as an area-lean alternative to the combinational sll/srl/sra shifters; the hazard unit stalls on o_ready low.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
STEP, 1, bit positions shifted per BUSY cycle; power of two in {1,2,4,8,16}.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  request valid.
o_ready  output  1  unit can accept a request; high only in IDLE.
i_op  input  2  operation code: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
i_operand_a  input  32  value to be shifted.
i_operand_b  input  5  shift amount, 0..31.
i_flush  input  1  synchronous abort of any in-flight request.
o_valid  output  1  result valid; one-cycle pulse.
o_result  output  32  shifted value; held between pulses.

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE, o_ready=1, o_valid=0, o_result=32'h0, and internal data/remaining/op cleared.
- States: IDLE, BUSY, DONE.
- Accept occurs on a rising edge with state==IDLE, i_valid=1 and i_flush=0. On accept, latch i_operand_a into the data register, i_operand_b into rem, and i_op.
  - If i_operand_b==0 or i_op==11, go to DONE with data unchanged.
  - Otherwise go to BUSY.
- BUSY, each edge:
  - s = (rem < STEP) ? rem : STEP.
  - SLL: data <<= s. SRL: data >>= s (zero fill). SRA: arithmetic right shift by s, filling with the latched bit 31.
  - rem -= s. When the new rem==0, go to DONE.
- DONE:
  - o_valid=1 for exactly one cycle and o_result=data.
  - On the next edge, return to IDLE.
  - No new request is accepted in DONE.
- Latency: o_valid is high in the cycle after edge number 1 + ceil(shamt/STEP), counting the accept edge as 1.
  - STEP=1, shamt=31: 32 edges.
  - STEP=4, shamt=31: 9 edges.
  - shamt=0: 1 edge.
- o_result updates only on entry to DONE and holds until the next DONE; the final result is registered.
- o_ready = (state==IDLE), combinational from state only (no path from i_valid).
- i_valid while BUSY/DONE is ignored; the requester must hold its request until o_ready.
- i_flush:
  - In BUSY or DONE, the next state is IDLE, o_valid is not asserted afterwards, and o_result keeps its previous value.
  - In IDLE, i_flush blocks acceptance; i_flush has priority over i_valid.
- Reset mid-operation: immediate return to the reset values; no o_valid.
- A shift result must equal opa<<opb, opa>>opb, or $signed(opa)>>>opb exactly, for all opb 0..31.

Decomposition:
- shift_pkg holds:
  - typedef enum logic [1:0] shift_op_e {OP_SLL, OP_SRL, OP_SRA, OP_RSVD};
  - typedef enum logic [1:0] shift_state_e {S_IDLE, S_BUSY, S_DONE};
  - localparam XLEN=32.
- One combinational sub-module, shift_step (inputs data, op, s[4:0]; output data_next), instantiated once. It is the only place the shift arithmetic lives.
- The FSM, rem counter and handshake stay in seq_shift_unit.

Test Plan:
- STEP=1, op SLL, a=32'h0F0F0F0F, b=4 → o_valid 5 edges after accept, o_result=32'hF0F0F0F0; o_ready low for those cycles.
- STEP=1, op SRA, a=32'hF0F0F0F0, b=31 → o_valid after 32 edges, o_result=32'hFFFFFFFF. Repeat with op SRL → 32'h00000001.
- STEP=4, sweep b=0..31 for a=32'h0F0F0F0F and a=32'hF0F0F0F0, all three ops → every result matches the <<, >> and >>> reference. Latency is 1+ceil(b/4); b=0 gives o_valid 1 edge after accept.
- Flush: STEP=1, SRL a=32'hF0F0F0F0, b=20, assert i_flush 5 cycles after accept → no o_valid, o_ready high next cycle, o_result unchanged from the previous result. A following SLL a=1, b=3 returns 32'h00000008.
- Async reset mid-BUSY (i_rst_n low between edges) → o_valid=0, o_ready=1, o_result=0 immediately. No pulse after release.
- i_valid held high through BUSY/DONE with changing operands → only the operands present at an IDLE edge are used. Exactly one o_valid per accept; op 11 with a=32'h12345678 returns 32'h12345678 after 1 edge.
